// File: rtl/pong_renderer.sv
// Pong scene renderer: latches sprite positions once per frame and turns the
// current pixel coordinate into a colour through a fixed two-stage pipeline.
module pong_renderer #(
    parameter int                X_POS_W       = 10,
    parameter int                Y_POS_W       = 10,
    parameter int                SCREEN_H_RES  = 640,
    parameter int                SCREEN_V_RES  = 480,
    parameter int                SCREEN_BORDER = 8,
    parameter int                PADDLE_WIDTH  = 8,
    parameter int                PADDLE_HEIGHT = 64,
    parameter int                BALL_SIDE     = 8,
    parameter int                RGB_W         = 12,
    parameter logic [RGB_W-1:0]  COL_BALL      = 12'hFFF,
    parameter logic [RGB_W-1:0]  COL_PLAYER    = 12'h0F0,
    parameter logic [RGB_W-1:0]  COL_ENEMY     = 12'hF00,
    parameter logic [RGB_W-1:0]  COL_NET       = 12'h888,
    parameter logic [RGB_W-1:0]  COL_BORDER    = 12'h00F,
    parameter logic [RGB_W-1:0]  COL_BG        = 12'h000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               new_frame_i,
    input  logic [X_POS_W-1:0] player_x_i,
    input  logic [Y_POS_W-1:0] player_y_i,
    input  logic [X_POS_W-1:0] enemy_x_i,
    input  logic [Y_POS_W-1:0] enemy_y_i,
    input  logic [X_POS_W-1:0] ball_x_i,
    input  logic [Y_POS_W-1:0] ball_y_i,
    input  logic [X_POS_W-1:0] pixel_x_i,
    input  logic [Y_POS_W-1:0] pixel_y_i,
    input  logic               visible_i,
    input  logic               hsync_i,
    input  logic               vsync_i,
    output logic [RGB_W-1:0]   rgb_o,
    output logic               hsync_o,
    output logic               vsync_o
);

    localparam logic [X_POS_W-1:0] NET_X_L    = X_POS_W'(SCREEN_H_RES / 2 - 1);
    localparam logic [X_POS_W-1:0] NET_X_R    = X_POS_W'(SCREEN_H_RES / 2);
    localparam logic [Y_POS_W-1:0] BORDER_TOP = Y_POS_W'(SCREEN_BORDER);
    localparam logic [Y_POS_W-1:0] BORDER_BOT = Y_POS_W'(SCREEN_V_RES - SCREEN_BORDER);

    // The extra top bit keeps pos+size from wrapping back to column/row 0.
    function automatic logic hit_x(input logic [X_POS_W-1:0] pix,
                                   input logic [X_POS_W-1:0] pos,
                                   input int                 size);
        return (pix >= pos) &&
               ({1'b0, pix} < ({1'b0, pos} + (X_POS_W+1)'(size)));
    endfunction

    function automatic logic hit_y(input logic [Y_POS_W-1:0] pix,
                                   input logic [Y_POS_W-1:0] pos,
                                   input int                 size);
        return (pix >= pos) &&
               ({1'b0, pix} < ({1'b0, pos} + (Y_POS_W+1)'(size)));
    endfunction

    logic [X_POS_W-1:0] player_x_r, enemy_x_r, ball_x_r;
    logic [Y_POS_W-1:0] player_y_r, enemy_y_r, ball_y_r;

    logic ball_hit_s, player_hit_s, enemy_hit_s, net_hit_s, border_hit_s;
    logic ball_hit_r, player_hit_r, enemy_hit_r, net_hit_r, border_hit_r;
    logic visible_d1_r, hsync_d1_r, vsync_d1_r;

    logic [RGB_W-1:0] rgb_r;
    logic             hsync_r, vsync_r;

    // Shadow copies of the sprite positions, refreshed only at frame start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            player_x_r <= {X_POS_W{1'b0}};
            player_y_r <= {Y_POS_W{1'b0}};
            enemy_x_r  <= {X_POS_W{1'b0}};
            enemy_y_r  <= {Y_POS_W{1'b0}};
            ball_x_r   <= {X_POS_W{1'b0}};
            ball_y_r   <= {Y_POS_W{1'b0}};
        end else if (new_frame_i) begin
            player_x_r <= player_x_i;
            player_y_r <= player_y_i;
            enemy_x_r  <= enemy_x_i;
            enemy_y_r  <= enemy_y_i;
            ball_x_r   <= ball_x_i;
            ball_y_r   <= ball_y_i;
        end else begin
            player_x_r <= player_x_r;
            player_y_r <= player_y_r;
            enemy_x_r  <= enemy_x_r;
            enemy_y_r  <= enemy_y_r;
            ball_x_r   <= ball_x_r;
            ball_y_r   <= ball_y_r;
        end
    end

    // Per-element hit tests against the current pixel.
    always_comb begin
        ball_hit_s   = hit_x(pixel_x_i, ball_x_r, BALL_SIDE) &&
                       hit_y(pixel_y_i, ball_y_r, BALL_SIDE);
        player_hit_s = hit_x(pixel_x_i, player_x_r, PADDLE_WIDTH) &&
                       hit_y(pixel_y_i, player_y_r, PADDLE_HEIGHT);
        enemy_hit_s  = hit_x(pixel_x_i, enemy_x_r, PADDLE_WIDTH) &&
                       hit_y(pixel_y_i, enemy_y_r, PADDLE_HEIGHT);
        // Two-pixel-wide net drawn as 16-row dashes.
        net_hit_s    = ((pixel_x_i == NET_X_L) || (pixel_x_i == NET_X_R)) &&
                       (pixel_y_i[4] == 1'b0);
        border_hit_s = (pixel_y_i < BORDER_TOP) || (pixel_y_i >= BORDER_BOT);
    end

    // Stage 1: hit flags plus visible/sync delayed alongside them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ball_hit_r   <= 1'b0;
            player_hit_r <= 1'b0;
            enemy_hit_r  <= 1'b0;
            net_hit_r    <= 1'b0;
            border_hit_r <= 1'b0;
            visible_d1_r <= 1'b0;
            hsync_d1_r   <= 1'b1;
            vsync_d1_r   <= 1'b1;
        end else begin
            ball_hit_r   <= ball_hit_s;
            player_hit_r <= player_hit_s;
            enemy_hit_r  <= enemy_hit_s;
            net_hit_r    <= net_hit_s;
            border_hit_r <= border_hit_s;
            visible_d1_r <= visible_i;
            hsync_d1_r   <= hsync_i;
            vsync_d1_r   <= vsync_i;
        end
    end

    // Stage 2: priority colour select, blanked outside the active area.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rgb_r   <= {RGB_W{1'b0}};
            hsync_r <= 1'b1;
            vsync_r <= 1'b1;
        end else begin
            hsync_r <= hsync_d1_r;
            vsync_r <= vsync_d1_r;
            if (!visible_d1_r)     rgb_r <= {RGB_W{1'b0}};
            else if (ball_hit_r)   rgb_r <= COL_BALL;
            else if (player_hit_r) rgb_r <= COL_PLAYER;
            else if (enemy_hit_r)  rgb_r <= COL_ENEMY;
            else if (net_hit_r)    rgb_r <= COL_NET;
            else if (border_hit_r) rgb_r <= COL_BORDER;
            else                   rgb_r <= COL_BG;
        end
    end

    assign rgb_o   = rgb_r;
    assign hsync_o = hsync_r;
    assign vsync_o = vsync_r;

endmodule
